// File: rtl/axis_seq_append_pkg.sv
// axis_seq_append_pkg: shared FSM state encoding for the sequence-append tagger
package axis_seq_append_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_SEQ  = 2'd2
    } state_t;
endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg: registered valid/ready output slice
//   clk, rst_n            clock, async active-low reset
//   in_valid, in_data     payload offered for loading
//   load_en               register can take a new payload this cycle
//   out_valid, out_data   registered outputs, held while out_valid && !out_ready
//   out_ready             downstream ready
module axis_out_reg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         load_en,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready
);
    assign load_en = !out_valid || out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_en) begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
        end
    end
endmodule

// File: rtl/axis_seq_append.sv
// axis_seq_append: AXI-Stream packet forwarder that appends a sequence-number trailer
//   m_axis_aclk, m_axis_aresetn   clock, async active-low reset
//   ctrl_seq_en                   sampled at first beat: 1 append trailer, 0 passthrough
//   s_axis_*                      input stream (tvalid/tdata/tlast/tready)
//   m_axis_*                      registered output stream
//   stat_seq                      sequence number the next trailer will carry
module axis_seq_append
    import axis_seq_append_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int SEQ_W    = 16,
    parameter int SEQ_INIT = 1
) (
    input  logic              m_axis_aclk,
    input  logic              m_axis_aresetn,
    input  logic              ctrl_seq_en,
    input  logic              s_axis_tvalid,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              m_axis_tvalid,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic [SEQ_W-1:0]  stat_seq
);
    state_t state, state_nx;
    logic en_q, tr_q, load_en, accept, in_en, ld_valid, ld_last;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W:0] out_pl;
    assign s_axis_tready = load_en && state != S_SEQ && m_axis_aresetn;
    assign accept = s_axis_tvalid && s_axis_tready;
    // first beat uses the live enable, later beats the one latched at packet start
    assign in_en = state == S_IDLE ? ctrl_seq_en : en_q;
    always_comb begin
        state_nx = state;
        ld_valid = accept;
        ld_data  = s_axis_tdata;
        ld_last  = s_axis_tlast & ~in_en;
        if (state == S_SEQ) begin
            ld_valid = load_en;
            ld_data  = DATA_W'(stat_seq);
            ld_last  = 1'b1;
            if (load_en) state_nx = S_IDLE;
        end else if (accept) begin
            state_nx = !s_axis_tlast ? S_PASS : in_en ? S_SEQ : S_IDLE;
        end
    end
    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state    <= S_IDLE;
            en_q     <= 1'b0;
            tr_q     <= 1'b0;
            stat_seq <= SEQ_W'(SEQ_INIT);
        end else begin
            state <= state_nx;
            if (accept && state == S_IDLE) en_q <= ctrl_seq_en;
            // tr_q marks that the word sitting in the output register is a trailer
            if (load_en) tr_q <= state == S_SEQ;
            if (m_axis_tvalid && m_axis_tready && tr_q)
                stat_seq <= stat_seq == '1 ? SEQ_W'(SEQ_INIT) : stat_seq + 1'b1;
        end
    end
    axis_out_reg #(.W(DATA_W + 1)) u_out (
        .clk      (m_axis_aclk),
        .rst_n    (m_axis_aresetn),
        .in_valid (ld_valid),
        .in_data  ({ld_last, ld_data}),
        .load_en  (load_en),
        .out_valid(m_axis_tvalid),
        .out_data (out_pl),
        .out_ready(m_axis_tready)
    );
    assign m_axis_tlast = out_pl[DATA_W];
    assign m_axis_tdata = out_pl[DATA_W-1:0];
endmodule

// File: tb/tb_axis_seq_append.sv
// tb_axis_seq_append: scoreboard bench driving a 16-bit and a 4-bit counter instance in lockstep
module tb_axis_seq_append;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic [31:0] s_data = '0;
    logic sr0, sr1, mv0, mv1, ml0, ml1;
    logic [31:0] md0, md1;
    logic [15:0] st0;
    logic [3:0] st1;
    int checks = 0, errors = 0, cyc = 0, last_hs = -1, rmode = 0;
    bit b2b = 0;
    logic [15:0] s16 = 16'd1;
    logic [3:0] s4 = 4'd1;
    logic [32:0] q[2][$];
    logic [32:0] mo[2], hold_v[2];
    logic mvv[2];
    bit held[2];

    always #5 clk = ~clk;

    axis_seq_append #(.DATA_W(32), .SEQ_W(16), .SEQ_INIT(1)) dut16 (
        .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .ctrl_seq_en(en),
        .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tlast(s_last), .s_axis_tready(sr0),
        .m_axis_tvalid(mv0), .m_axis_tdata(md0), .m_axis_tlast(ml0), .m_axis_tready(m_ready),
        .stat_seq(st0));
    axis_seq_append #(.DATA_W(32), .SEQ_W(4), .SEQ_INIT(1)) dut4 (
        .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .ctrl_seq_en(en),
        .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tlast(s_last), .s_axis_tready(sr1),
        .m_axis_tvalid(mv1), .m_axis_tdata(md1), .m_axis_tlast(ml1), .m_axis_tready(m_ready),
        .stat_seq(st1));

    assign mo[0] = {ml0, md0};
    assign mo[1] = {ml1, md1};
    assign mvv[0] = mv0;
    assign mvv[1] = mv1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;

    // monitor: samples mid-cycle, a handshake completes on the following posedge
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (!rst_n) begin
            held[0] = 0;
            held[1] = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (held[k]) chk($sformatf("stable%0d", k), {31'b0, mvv[k], mo[k]}, {31'b0, 1'b1, hold_v[k]});
                held[k] = 0;
                if (mvv[k] && m_ready) begin
                    if (q[k].size() == 0) chk($sformatf("unexpected%0d", k), {31'b0, mo[k]}, 64'hdead);
                    else chk($sformatf("out%0d", k), {31'b0, mo[k]}, {31'b0, q[k].pop_front()});
                    if (k == 0 && b2b) begin
                        if (last_hs >= 0) chk("b2b_gap", 64'(cyc - last_hs), 64'd1);
                        last_hs = cyc;
                    end
                end else if (mvv[k]) begin
                    held[k] = 1;
                    hold_v[k] = mo[k];
                end
            end
        end
    end

    task automatic beat(input logic [31:0] d, input logic l);
        bit done = 0;
        int n = 0;
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        while (!done) begin
            #1;
            done = sr0;
            @(posedge clk);
            @(negedge clk);
            if (!done && ++n > 1000) begin
                chk("beat_timeout", 64'(n), 64'd0);
                done = 1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit pen, input bit tog, input logic [31:0] base);
        en = pen;
        for (int i = 0; i < n; i++) begin
            q[0].push_back({(i == n - 1) & ~pen, base + 32'(i)});
            q[1].push_back({(i == n - 1) & ~pen, base + 32'(i)});
            beat(base + 32'(i), i == n - 1);
            if (i == 0 && tog) en = ~pen;
        end
        if (pen) begin
            q[0].push_back({1'b1, 16'b0, s16});
            q[1].push_back({1'b1, 28'b0, s4});
            s16 = s16 + 16'd1;
            s4 = s4 == 4'hf ? 4'd1 : s4 + 4'd1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(q[0].size() + q[1].size()), 64'd0);
        @(negedge clk);
        #3;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q[0].delete();
        q[1].delete();
        s16 = 16'd1;
        s4 = 4'd1;
        #1;
        chk("rst_out", {mv0, ml0, md0, mv1, ml1, md1}, 64'd0);
        chk("rst_ready", {sr0, sr1}, 64'd0);
        chk("rst_seq", {st0, 12'b0, st1}, {16'd1, 12'b0, 4'd1});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();
        send_pkt(3, 1, 0, 32'hA0);
        drain();
        chk("t1_seq", {st0, 12'b0, st1}, {16'd2, 12'b0, 4'd2});

        do_reset();
        last_hs = -1;
        b2b = 1;
        send_pkt(1, 1, 0, 32'hD0);
        send_pkt(1, 1, 0, 32'hE0);
        drain();
        b2b = 0;
        chk("t2_seq", 64'(st0), 64'd3);

        do_reset();
        rmode = 1;
        for (int p = 0; p < 100; p++) send_pkt((p % 4) + 1, 1, 0, 32'(p * 16 + 32'h1000));
        drain();
        chk("t3_seq16", 64'(st0), 64'd101);
        chk("t3_seq4", 64'(st1), 64'(s4));

        send_pkt(3, 0, 1, 32'hC000);
        send_pkt(1, 0, 0, 32'hC100);
        drain();
        rmode = 0;
        chk("t4_seq16", 64'(st0), 64'd101);
        chk("t4_seq4", 64'(st1), 64'(s4));

        do_reset();
        for (int p = 0; p < 20; p++) send_pkt(1, 1, 0, 32'(32'h500 + p));
        drain();
        chk("t5_seq4", 64'(st1), 64'd6);
        chk("t5_seq16", 64'(st0), 64'd21);

        do_reset();
        rmode = 2;
        send_pkt(1, 1, 0, 32'hF0);
        repeat (3) @(negedge clk);
        #1;
        chk("t6_stall_ready", {sr0, sr1}, 64'd0);
        chk("t6_stall_valid", {mv0, mv1}, 64'd3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {mv0, mv1}, 64'd0);
        q[0].delete();
        q[1].delete();
        s16 = 16'd1;
        s4 = 4'd1;
        rmode = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_pkt(1, 1, 0, 32'hF1);
        drain();
        chk("t6_seq", {st0, 12'b0, st1}, {16'd2, 12'b0, 4'd2});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
